tape_pulse_player: RTL and testbench

TAPE_PULSE_PLAYER -- requirements
Module: tape_pulse_player

---
 rtl/tape_pkg.sv | 25 ++
 rtl/tape_tick_prescaler.sv | 40 ++++
 rtl/tape_pulse_player.sv | 93 +++++++++
 tb/tb_tape_pulse_player.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
// Shared definitions for the tape pulse player: FSM states,
// pulse word layout and default tick dividers.
package tape_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_COUNT
    } state_t;

    localparam int WORD_W         = 16;
    localparam int LEVEL_BIT      = 15;
    localparam int LEN_W          = 15;
    localparam int PRE_W          = 16;
    localparam int DIV_NORMAL_DEF = 56;
    localparam int DIV_TURBO_DEF  = 28;

    function automatic logic [LEN_W-1:0] pulse_len(
        input logic [WORD_W-1:0] w
    );
        return w[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/tape_tick_prescaler.sv
// Tick prescaler for the tape pulse player.
// Ports: i_clock, i_reset, i_clear (hold at 0), i_turbo (divider
// select, sampled every cycle), o_tick (one-cycle tick).
module tape_tick_prescaler
    import tape_pkg::*;
#(
    parameter int DIV_NORMAL = DIV_NORMAL_DEF,
    parameter int DIV_TURBO  = DIV_TURBO_DEF
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_turbo,
    output logic o_tick
);

    localparam logic [PRE_W-1:0] NORM_M1 = PRE_W'(DIV_NORMAL - 1);
    localparam logic [PRE_W-1:0] TURB_M1 = PRE_W'(DIV_TURBO - 1);

    logic [PRE_W-1:0] r_presc;
    logic [PRE_W-1:0] w_limit;
    logic             w_wrap;

    // ">=" so a switch to the shorter divider mid-pulse still wraps
    // when the count is already past the new limit.
    assign w_limit = i_turbo ? TURB_M1 : NORM_M1;
    assign w_wrap  = (r_presc >= w_limit);
    assign o_tick  = w_wrap & ~i_clear & ~i_reset;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_presc <= '0;
        end else if (w_wrap) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

endmodule

// File: rtl/tape_pulse_player.sv
// Replays tape pulse words from a FIFO as an EAR level stream.
// Ports: i_clock, i_reset, i_clear_fifo, i_load_turbo, i_fifo_empty,
// i_fifo_q (level + length) in; o_fifo_rdreq, o_ear, o_playing,
// o_underrun out.
module tape_pulse_player
    import tape_pkg::*;
#(
    parameter int DIV_NORMAL = DIV_NORMAL_DEF,
    parameter int DIV_TURBO  = DIV_TURBO_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_clear_fifo,
    input  logic              i_load_turbo,
    input  logic              i_fifo_empty,
    input  logic [WORD_W-1:0] i_fifo_q,
    output logic              o_fifo_rdreq,
    output logic              o_ear,
    output logic              o_playing,
    output logic              o_underrun
);

    state_t           r_state;
    logic [LEN_W-1:0] r_count;
    logic             r_ear;
    logic             r_underrun;
    logic [LEN_W-1:0] w_len;
    logic             w_tick;
    logic             w_presc_clr;

    assign w_len       = pulse_len(i_fifo_q);
    // Prescaler only runs while a pulse is being timed.
    assign w_presc_clr = i_clear_fifo | (r_state != ST_COUNT);

    tape_tick_prescaler #(
        .DIV_NORMAL (DIV_NORMAL),
        .DIV_TURBO  (DIV_TURBO)
    ) u_presc (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (w_presc_clr),
        .i_turbo (i_load_turbo),
        .o_tick  (w_tick)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear_fifo) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_ear      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!i_fifo_empty) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_len != '0) begin
                        r_ear   <= i_fifo_q[LEVEL_BIT];
                        r_count <= w_len;
                        r_state <= ST_COUNT;
                    end else begin
                        // Zero-length word: skip without touching EAR.
                        r_state <= i_fifo_empty ? ST_IDLE : ST_FETCH;
                    end
                end
                ST_COUNT: begin
                    if (w_tick && r_count != '0) begin
                        r_count <= r_count - 1'b1;
                        if (r_count == LEN_W'(1)) begin
                            if (i_fifo_empty) begin
                                r_state    <= ST_IDLE;
                                r_underrun <= 1'b1;
                            end else begin
                                r_state <= ST_FETCH;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_fifo_rdreq = (r_state == ST_FETCH) & ~i_clear_fifo & ~i_reset;
    assign o_ear        = r_ear;
    assign o_playing    = (r_state != ST_IDLE);
    assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_tape_pulse_player.sv
// Randomized self-checking bench for tape_pulse_player with a
// timeline reference model and directed corner cases.
module tb_tape_pulse_player;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_clear_fifo = 1'b0;
    logic        i_load_turbo = 1'b0;
    logic        i_fifo_empty = 1'b1;
    logic [15:0] i_fifo_q = 16'h0;
    logic        o_fifo_rdreq;
    logic        o_ear;
    logic        o_playing;
    logic        o_underrun;

    tape_pulse_player #(
        .DIV_NORMAL (56),
        .DIV_TURBO  (28)
    ) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_clear_fifo (i_clear_fifo),
        .i_load_turbo (i_load_turbo),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_q     (i_fifo_q),
        .o_fifo_rdreq (o_fifo_rdreq),
        .o_ear        (o_ear),
        .o_playing    (o_playing),
        .o_underrun   (o_underrun)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          base = 0;
    int          n_rd = 0;
    logic        last_ear = 1'b0;
    logic [15:0] fq[$];
    logic [15:0] scen[$];
    int          ev_t[$];
    int          ev_l[$];
    int          exp_t[$];
    int          exp_l[$];
    int          exp_end;
    int          exp_ur;
    int          exp_ear;

    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // One clock: sample rdreq before the edge, serve the FIFO and
    // record EAR transitions at the following falling edge.
    task automatic tick();
        logic rd;
        #1 rd = o_fifo_rdreq;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (rd) begin
            n_rd++;
            if (fq.size() > 0) i_fifo_q = fq.pop_front();
        end
        i_fifo_empty = (fq.size() == 0);
        if (o_ear !== last_ear) begin
            ev_t.push_back(cyc);
            ev_l.push_back(int'(o_ear));
            last_ear = o_ear;
        end
    endtask

    task automatic push(input logic [15:0] w);
        fq.push_back(w);
        i_fifo_empty = 1'b0;
    endtask

    task automatic flush();
        fq.delete();
        i_fifo_empty = 1'b1;
    endtask

    task automatic do_clear();
        i_clear_fifo = 1'b1;
        flush();
        tick();
        i_clear_fifo = 1'b0;
        ev_t.delete();
        ev_l.delete();
        n_rd = 0;
    endtask

    // Timeline model: the FSM enters FETCH one edge after words
    // appear; each word costs FETCH+LOAD (2 edges) plus len*div
    // edges of counting when len is non-zero.
    task automatic model(input int div);
        int  f;
        int  len;
        int  lvl;
        exp_t.delete();
        exp_l.delete();
        lvl = 0;
        f = 1;
        exp_ur = 0;
        foreach (scen[i]) begin
            len = int'(scen[i][14:0]);
            if (len == 0) begin
                f += 2;
                exp_ur = 0;
            end else begin
                if (int'(scen[i][15]) != lvl) begin
                    lvl = int'(scen[i][15]);
                    exp_t.push_back(f + 2);
                    exp_l.push_back(lvl);
                end
                f = f + 2 + len * div;
                exp_ur = 1;
            end
        end
        exp_end = f;
        exp_ear = lvl;
    endtask

    task automatic run_scen(input logic turbo);
        do_clear();
        i_load_turbo = turbo;
        model(turbo ? 28 : 56);
        base = cyc;
        foreach (scen[i]) push(scen[i]);
        while (cyc < base + exp_end - 1) tick();
        check("playing_before_end", int'(o_playing), 1);
        tick();
        check("playing_after_end", int'(o_playing), 0);
        check("underrun_end", int'(o_underrun), exp_ur);
        check("ear_end", int'(o_ear), exp_ear);
        check("rdreq_count", n_rd, scen.size());
        check("edge_count", ev_t.size(), exp_t.size());
        for (int i = 0; i < exp_t.size() && i < ev_t.size(); i++) begin
            check("edge_time", ev_t[i] - base, exp_t[i]);
            check("edge_level", ev_l[i], exp_l[i]);
        end
    endtask

    initial begin
        repeat (3) tick();
        check("rst_rdreq", int'(o_fifo_rdreq), 0);
        check("rst_playing", int'(o_playing), 0);
        check("rst_ear", int'(o_ear), 0);
        check("rst_underrun", int'(o_underrun), 0);
        i_reset = 1'b0;
        tick();

        // Single normal-mode pulse ending in underrun.
        scen = '{16'h8003};
        run_scen(1'b0);

        // Turbo back-to-back pulses, 58-cycle edge spacing.
        scen = '{16'h8002, 16'h0002, 16'h8002};
        run_scen(1'b1);
        if (ev_t.size() == 3) begin
            check("turbo_space0", ev_t[1] - ev_t[0], 58);
            check("turbo_space1", ev_t[2] - ev_t[1], 58);
        end else begin
            check("turbo_edges", ev_t.size(), 3);
        end

        // Zero-length word is skipped between two pulses.
        scen = '{16'h8001, 16'h0000, 16'h0001};
        run_scen(1'b0);

        // Underrun is sticky until cleared; clear mid-count.
        scen = '{16'h8001};
        run_scen(1'b0);
        base = cyc;
        push(16'h8008);
        while (cyc < base + 3 + 170) tick();
        check("sticky_underrun", int'(o_underrun), 1);
        check("sticky_playing", int'(o_playing), 1);
        i_clear_fifo = 1'b1;
        flush();
        tick();
        i_clear_fifo = 1'b0;
        check("clr_playing", int'(o_playing), 0);
        check("clr_ear", int'(o_ear), 0);
        check("clr_underrun", int'(o_underrun), 0);

        // Clear landing on the FETCH cycle suppresses the read.
        n_rd = 0;
        base = cyc;
        push(16'h8005);
        tick();
        i_clear_fifo = 1'b1;
        flush();
        #1 check("clr_fetch_rdreq", int'(o_fifo_rdreq), 0);
        tick();
        i_clear_fifo = 1'b0;
        check("clr_fetch_playing", int'(o_playing), 0);
        check("clr_fetch_nrd", n_rd, 0);

        // Normal -> turbo switch at prescaler 40 forces a wrap.
        do_clear();
        i_load_turbo = 1'b0;
        base = cyc;
        push(16'h8002);
        while (cyc < base + 43) tick();
        check("sw_playing", int'(o_playing), 1);
        i_load_turbo = 1'b1;
        while (cyc < base + 71) tick();
        check("sw_before_end", int'(o_playing), 1);
        tick();
        check("sw_after_end", int'(o_playing), 0);
        check("sw_underrun", int'(o_underrun), 1);
        i_load_turbo = 1'b0;

        // Reset held 3 cycles in the middle of a pulse.
        do_clear();
        base = cyc;
        push(16'h8004);
        push(16'h0004);
        while (cyc < base + 50) tick();
        i_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check("mrst_rdreq", int'(o_fifo_rdreq), 0);
            tick();
            check("mrst_playing", int'(o_playing), 0);
            check("mrst_ear", int'(o_ear), 0);
            check("mrst_underrun", int'(o_underrun), 0);
        end
        flush();
        i_reset = 1'b0;
        repeat (3) tick();
        check("mrst_idle", int'(o_playing), 0);
        check("mrst_ear_hold", int'(o_ear), 0);

        // Reset landing on FETCH forces rdreq low.
        n_rd = 0;
        push(16'h8003);
        tick();
        i_reset = 1'b1;
        #1 check("frst_rdreq", int'(o_fifo_rdreq), 0);
        tick();
        flush();
        i_reset = 1'b0;
        tick();
        check("frst_playing", int'(o_playing), 0);
        check("frst_nrd", n_rd, 0);

        // Randomized pulse trains.
        for (int s = 0; s < 12; s++) begin
            int n;
            logic [15:0] w;
            scen.delete();
            n = int'($urandom_range(1, 5));
            for (int j = 0; j < n; j++) begin
                w[15] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 4) == 0) w[14:0] = 15'd0;
                else w[14:0] = 15'($urandom_range(1, 4));
                scen.push_back(w);
            end
            run_scen(1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
